record_play_controller: RTL

- Sequences the PDM deserializer and a single-port sample RAM for the audio recorder.
- RECORD: enables the deserializer and writes each completed 16-bit sample to consecutive RAM addresses.
- PLAY: reads the stored samples back at a fixed sample rate for the output stage.
- Sits between the user-command logic, the deserializer and the RAM. Owns the RAM address and recorded length.

---
 rtl/record_play_controller.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/record_play_controller.sv
// rtl/record_play_controller.sv - record/playback sequencer between PDM deserializer and sample RAM
// Records synchronized deserializer samples to RAM and replays them at a fixed sample rate.
module record_play_controller #(
  parameter int ADDR_W     = 14,
  parameter int SAMPLE_DIV = 1600
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              record_i,
  input  logic              play_i,
  input  logic              stop_i,
  input  logic              deser_done_i,
  input  logic [15:0]       deser_data_i,
  output logic              deser_enable_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [15:0]       mem_wdata_o,
  input  logic [15:0]       mem_rdata_i,
  output logic [15:0]       play_data_o,
  output logic              play_valid_o,
  output logic              busy_o,
  output logic [1:0]        state_o,
  output logic [ADDR_W:0]   length_o
);

  localparam int DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REC  = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              sync1_q, sync2_q, prev_q;
  logic              pend_q, pend_d;
  logic              we_q, we_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [15:0]       held_q, held_d;

  logic sample_event;
  logic rd_issue;
  logic last_write;

  assign sample_event = sync2_q & ~prev_q;
  assign rd_issue     = (state_q == S_PLAY) && (div_q == '0);
  assign last_write   = we_q && (addr_q == LAST_ADDR);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (stop_i)                         state_d = S_IDLE;
        else if (record_i)                  state_d = S_REC;
        else if (play_i && (len_q != '0))   state_d = S_PLAY;
      end
      S_REC:  if (stop_i || last_write)          state_d = S_IDLE;
      S_PLAY: if (stop_i || (valid_q && last_q)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    deser_enable_o = (state_q == S_REC);
    busy_o         = (state_q != S_IDLE);
    state_o        = state_q;
    mem_addr_o     = (state_q == S_IDLE) ? '0 : addr_q;
    mem_we_o       = we_q;
    mem_wdata_o    = wdata_q;
    play_valid_o   = valid_q;
    play_data_o    = valid_q ? mem_rdata_i : held_q;
    length_o       = len_q;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      div_q   <= '0;
      pend_q  <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      held_q  <= '0;
    end else begin
      sync1_q <= deser_done_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      addr_q  <= addr_d;
      len_q   <= len_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      held_q  <= held_d;
    end
  end

  // A sample event is captured, then written one cycle later; the address advances after the write.
  always_comb begin
    addr_d  = addr_q;
    len_d   = len_q;
    div_d   = div_q;
    pend_d  = 1'b0;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    valid_d = rd_issue;
    last_d  = last_q;
    held_d  = valid_q ? mem_rdata_i : held_q;
    case (state_q)
      S_IDLE: begin
        if (state_d == S_REC) begin
          addr_d = '0;
          len_d  = '0;
        end else if (state_d == S_PLAY) begin
          addr_d = '0;
          div_d  = '0;
        end
      end
      S_REC: begin
        if (sample_event) wdata_d = deser_data_i;
        pend_d = sample_event && (state_d == S_REC);
        we_d   = pend_q && (state_d == S_REC);
        if (we_q) begin
          addr_d = addr_q + ADDR_W'(1);
          len_d  = len_q + (ADDR_W+1)'(1);
        end
      end
      S_PLAY: begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        if (rd_issue) begin
          addr_d = addr_q + ADDR_W'(1);
          last_d = (({1'b0, addr_q} + (ADDR_W+1)'(1)) == len_q);
        end
      end
      default: ;
    endcase
  end

endmodule
